bfly_stage1: RTL

Radix-2, span-32 butterfly stage directly downstream of `cbfp_stage0`. It consumes 64-point blocks of CBFP-normalised complex samples, delivered as four 16-lane batches. For each lane it forms x[n]+x[n+32] and x[n]−x[n+32], with one bit of growth, and emits them as a new 4-batch block. The per-sample CBFP index travels with each output sample for later denormalisation; twiddle multiplication belongs to the next stage.

---
 rtl/fft_pkg.sv | 34 +++
 rtl/bfly_stage1_if.sv | 33 +++
 rtl/bfly_stage1_lane.sv | 22 ++
 rtl/bfly_stage1.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the FFT pipeline stages.
//   BATCH_SIZE / BLOCK_SIZE : lanes per cycle / samples per block
//   BW_IN / BW_OUT          : stage-1 input and output real/imag widths
//   IDX_W                   : CBFP index width
//   cplx_in_t / cplx_out_t  : complex sample at input / output width
//   sext()                  : sign-extend one input component to BW_OUT
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int BW_IN      = 11;
  localparam int BW_OUT     = BW_IN + 1;
  localparam int IDX_W      = 5;
  localparam int BATCH_SIZE = 16;
  localparam int BLOCK_SIZE = 64;
  localparam int NUM_BATCH  = BLOCK_SIZE / BATCH_SIZE;
  localparam int BCNT_W     = $clog2(NUM_BATCH);

  typedef struct packed {
    logic signed [BW_IN-1:0] re;
    logic signed [BW_IN-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [BW_OUT-1:0] re;
    logic signed [BW_OUT-1:0] im;
  } cplx_out_t;

  function automatic logic signed [BW_OUT-1:0] sext(input logic signed [BW_IN-1:0] v);
    return {v[BW_IN-1], v};
  endfunction

endpackage

// File: rtl/bfly_stage1_if.sv
// -----------------------------------------------------------------------------
// bfly_stage1_if
// Batch bus of the span-32 butterfly stage.
//   in_valid                    : input batch present
//   real_in / imag_in / index_in: input batch, one entry per lane
//   valid_out                   : output batch valid
//   real_out / imag_out / index_out : output batch, one entry per lane
// Modports: slave = the butterfly stage, master = the upstream driver/sink.
// -----------------------------------------------------------------------------
interface bfly_stage1_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic signed [BW_IN-1:0]  real_in   [BATCH_SIZE];
  logic signed [BW_IN-1:0]  imag_in   [BATCH_SIZE];
  logic        [IDX_W-1:0]  index_in  [BATCH_SIZE];

  logic                     valid_out;
  logic signed [BW_OUT-1:0] real_out  [BATCH_SIZE];
  logic signed [BW_OUT-1:0] imag_out  [BATCH_SIZE];
  logic        [IDX_W-1:0]  index_out [BATCH_SIZE];

  modport slave (
    input  in_valid, real_in, imag_in, index_in,
    output valid_out, real_out, imag_out, index_out
  );

  modport master (
    output in_valid, real_in, imag_in, index_in,
    input  valid_out, real_out, imag_out, index_out
  );

endinterface

// File: rtl/bfly_stage1_lane.sv
// -----------------------------------------------------------------------------
// bfly_lane
// One lane of the radix-2 butterfly: sign-extends both operands by one bit and
// forms upper+lower and upper-lower. The result is exact at BW_OUT bits.
//   i_upper : sample n        i_lower : sample n+32
//   o_sum   : x[n]+x[n+32]    o_diff  : x[n]-x[n+32]
// -----------------------------------------------------------------------------
module bfly_lane
  import fft_pkg::*;
(
  input  cplx_in_t  i_upper,
  input  cplx_in_t  i_lower,
  output cplx_out_t o_sum,
  output cplx_out_t o_diff
);

  assign o_sum.re  = sext(i_upper.re) + sext(i_lower.re);
  assign o_sum.im  = sext(i_upper.im) + sext(i_lower.im);
  assign o_diff.re = sext(i_upper.re) - sext(i_lower.re);
  assign o_diff.im = sext(i_upper.im) - sext(i_lower.im);

endmodule

// File: rtl/bfly_stage1.sv
// -----------------------------------------------------------------------------
// bfly_stage1
// Radix-2, span-32 butterfly stage. Consumes 64-sample blocks as four 16-lane
// batches; batches 0/1 are held, batches 2/3 produce the sums (x[n]+x[n+32])
// directly and park the differences, which drain in the two following cycles.
// Output order per block: sums 0-15, 16-31, diffs 32-47, 48-63. Each output
// sample carries the CBFP index of its upper operand (sample n).
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : bfly_stage1_if.slave batch bus (registered outputs)
//   idx_err   : only with BFLY_IDX_CHECK_EN defined; sticky flag set when a
//               batch 2/3 lane index differs from the held batch 0/1 index
// -----------------------------------------------------------------------------
module bfly_stage1
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  bfly_stage1_if.slave  bus
`ifdef BFLY_IDX_CHECK_EN
  ,
  output logic          idx_err
`endif
);

  localparam logic [1:0] ST_FILL   = 2'b00;
  localparam logic [1:0] ST_SUM    = 2'b01;
  localparam logic [1:0] ST_DRAIN0 = 2'b10;
  localparam logic [1:0] ST_DRAIN1 = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [BCNT_W-1:0] r_bcnt;
  logic              w_do_fill;
  logic              w_do_sum;

  // Hold slots for batches 0/1 and diff slots for the two drain cycles.
  cplx_in_t         r_hold     [NUM_BATCH/2][BATCH_SIZE];
  logic [IDX_W-1:0] r_hold_idx [NUM_BATCH/2][BATCH_SIZE];
  cplx_out_t        r_diff     [NUM_BATCH/2][BATCH_SIZE];
  logic [IDX_W-1:0] r_diff_idx [NUM_BATCH/2][BATCH_SIZE];

  cplx_in_t         w_in_lane  [BATCH_SIZE];
  cplx_out_t        w_sum_lane [BATCH_SIZE];
  cplx_out_t        w_diff_lane[BATCH_SIZE];

  logic             r_valid;
  cplx_out_t        r_out      [BATCH_SIZE];
  logic [IDX_W-1:0] r_out_idx  [BATCH_SIZE];

  // bcnt[1] separates the fill half (0/1) from the butterfly half (2/3);
  // bcnt[0] selects the hold/diff slot in either half.
  assign w_do_fill = bus.in_valid && !r_bcnt[1];
  assign w_do_sum  = bus.in_valid &&  r_bcnt[1];

  for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_lane
    assign w_in_lane[gi] = {bus.real_in[gi], bus.imag_in[gi]};

    bfly_lane u_lane (
      .i_upper (r_hold[r_bcnt[0]][gi]),
      .i_lower (w_in_lane[gi]),
      .o_sum   (w_sum_lane[gi]),
      .o_diff  (w_diff_lane[gi])
    );

    assign bus.real_out[gi]  = r_out[gi].re;
    assign bus.imag_out[gi]  = r_out[gi].im;
    assign bus.index_out[gi] = r_out_idx[gi];
  end

  // Input acceptance continues during the drain, so a next-block batch 1 taken
  // in DRAIN1 moves straight on to SUM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:   if (bus.in_valid && r_bcnt == BCNT_W'(1)) w_state_nxt = ST_SUM;
      ST_SUM:    if (bus.in_valid && r_bcnt == BCNT_W'(3)) w_state_nxt = ST_DRAIN0;
      ST_DRAIN0: w_state_nxt = ST_DRAIN1;
      default:   w_state_nxt = (bus.in_valid && r_bcnt == BCNT_W'(1)) ? ST_SUM : ST_FILL;
    endcase
  end

  // NOTE: pure storage arrays carry no reset; their contents are only read after
  // being written within the current block, and leaving them unreset keeps them RAM-like.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (w_do_fill) begin
        r_hold[r_bcnt[0]][i]     <= w_in_lane[i];
        r_hold_idx[r_bcnt[0]][i] <= bus.index_in[i];
      end
      if (w_do_sum) begin
        r_diff[r_bcnt[0]][i]     <= w_diff_lane[i];
        r_diff_idx[r_bcnt[0]][i] <= r_hold_idx[r_bcnt[0]][i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_FILL;
      r_bcnt  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < BATCH_SIZE; i++) begin
        r_out[i]     <= '0;
        r_out_idx[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (bus.in_valid) r_bcnt <= r_bcnt + BCNT_W'(1);
      r_valid <= 1'b0;
      if (r_state == ST_DRAIN0 || r_state == ST_DRAIN1) begin
        // state bit 0 is the diff slot: DRAIN0 -> slot 0, DRAIN1 -> slot 1
        r_valid <= 1'b1;
        for (int i = 0; i < BATCH_SIZE; i++) begin
          r_out[i]     <= r_diff[r_state[0]][i];
          r_out_idx[i] <= r_diff_idx[r_state[0]][i];
        end
      end else if (w_do_sum) begin
        r_valid <= 1'b1;
        for (int i = 0; i < BATCH_SIZE; i++) begin
          r_out[i]     <= w_sum_lane[i];
          r_out_idx[i] <= r_hold_idx[r_bcnt[0]][i];
        end
      end
    end
  end

  assign bus.valid_out = r_valid;

`ifdef BFLY_IDX_CHECK_EN
  logic w_idx_mismatch;
  logic r_idx_err;

  always_comb begin
    w_idx_mismatch = 1'b0;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      if (bus.index_in[i] != r_hold_idx[r_bcnt[0]][i]) w_idx_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_idx_err <= 1'b0;
    else if (w_do_sum && w_idx_mismatch) r_idx_err <= 1'b1;
  end

  assign idx_err = r_idx_err;
`endif

endmodule
